// File: rtl/an_rx_pkg.sv
// an_rx_pkg: shared FSM encoding, default widths and width helper for the AN_RX level path
package an_rx_pkg;
  localparam int C_LV_W_DEF = 12;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_DECIDE} state_t;
  function automatic int log2c(input longint v);
    int r;
    r = 0;
    while ((longint'(1) << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/an_rx_hyst_deb.sv
// an_rx_hyst_deb: hysteretic threshold compare with debounce, updated once per averaged level
module an_rx_hyst_deb #(
  parameter int W     = 12,
  parameter int C_DEB = 3
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         stb,
  input  logic [W-1:0] avg,
  input  logic [W-1:0] th_on,
  input  logic [W-1:0] th_off,
  output logic         det
);
  logic [3:0] deb;
  logic [4:0] deb_inc;
  logic       qual, hit;
  always_comb begin
    qual    = det ? (avg < th_off) : (avg >= th_on);
    deb_inc = {1'b0, deb} + 5'd1;
    hit     = qual && deb_inc == 5'(C_DEB);
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      deb <= '0;
      det <= 1'b0;
    end else if (stb) begin
      deb <= (hit || !qual) ? '0 : deb_inc[3:0];
      if (hit) det <= !det;
    end
  end
endmodule

// File: rtl/an_rx_lv_sched.sv
// an_rx_lv_sched: periodic level-detector scheduler with timeout, averaging and debounced tone decision
module an_rx_lv_sched
  import an_rx_pkg::*;
#(
  parameter int C_LV_W     = C_LV_W_DEF,
  parameter int C_AVG_LOG2 = 2,
  parameter int C_PERIOD   = 48000,
  parameter int C_TIMEOUT  = 96000,
  parameter int C_DEB      = 3
)(
  input  logic              CK_i,
  input  logic              SRST_i,
  input  logic              EN_i,
  input  logic              DONE_i,
  input  logic [C_LV_W-1:0] LVs_i,
  input  logic [C_LV_W-1:0] TH_ON_i,
  input  logic [C_LV_W-1:0] TH_OFF_i,
  output logic              START_o,
  output logic [C_LV_W-1:0] AVGs_o,
  output logic              AVG_VLD_o,
  output logic              DET_o,
  output logic              TMO_o,
  output logic              BUSY_o
);
  localparam int N     = 1 << C_AVG_LOG2;
  localparam int SUM_W = C_LV_W + C_AVG_LOG2;
  localparam int P_W   = log2c(C_PERIOD);
  localparam int T_W   = log2c(C_TIMEOUT);
  localparam int C_W   = C_AVG_LOG2 + 1;
  state_t            state, nxt;
  logic [P_W-1:0]    pcnt;
  logic [T_W-1:0]    tcnt;
  logic [C_W-1:0]    cnt;
  logic [SUM_W-1:0]  sum, sum_add;
  logic [C_LV_W-1:0] smp;
  logic              tick, last, tmo_hit, timeout, dec_stb;
  always_comb begin
    tick    = EN_i && pcnt == P_W'(C_PERIOD - 1);
    last    = cnt == C_W'(N - 1);
    tmo_hit = tcnt == T_W'(C_TIMEOUT - 1);
    timeout = state == S_WAIT && !DONE_i && tmo_hit;
    dec_stb = EN_i && state == S_ACC && last;
    sum_add = sum + SUM_W'(smp);
    nxt = !EN_i              ? S_IDLE :
          state == S_IDLE    ? (tick ? S_WAIT : S_IDLE) :
          state == S_WAIT    ? (DONE_i ? S_ACC : tmo_hit ? S_IDLE : S_WAIT) :
          state == S_ACC     ? (last ? S_DECIDE : S_IDLE) :
                               S_IDLE;
    BUSY_o = state != S_IDLE;
  end
  always_ff @(posedge CK_i) begin
    state <= SRST_i ? S_IDLE : nxt;
  end
  // The average is latched on the final accumulate edge so it is visible during DECIDE
  always_ff @(posedge CK_i) begin
    if (SRST_i) AVGs_o <= '0;
    else if (dec_stb) AVGs_o <= C_LV_W'(sum_add >> C_AVG_LOG2);
  end
  always_ff @(posedge CK_i) begin
    if (SRST_i || !EN_i) begin
      pcnt      <= '0;
      tcnt      <= '0;
      sum       <= '0;
      cnt       <= '0;
      smp       <= '0;
      START_o   <= 1'b0;
      AVG_VLD_o <= 1'b0;
      TMO_o     <= 1'b0;
    end else begin
      pcnt      <= tick ? '0 : pcnt + P_W'(1);
      tcnt      <= state == S_WAIT ? tcnt + T_W'(1) : '0;
      START_o   <= state == S_IDLE && tick;
      AVG_VLD_o <= dec_stb;
      if (state == S_WAIT && DONE_i) smp <= LVs_i;
      if (timeout) begin
        TMO_o <= 1'b1;
        sum   <= '0;
        cnt   <= '0;
      end
      if (state == S_ACC) begin
        sum <= last ? '0 : sum_add;
        cnt <= last ? '0 : cnt + C_W'(1);
      end
    end
  end
  an_rx_hyst_deb #(.W(C_LV_W), .C_DEB(C_DEB)) u_hyst (
    .clk    (CK_i),
    .rst    (SRST_i),
    .clr    (!EN_i),
    .stb    (dec_stb),
    .avg    (C_LV_W'(sum_add >> C_AVG_LOG2)),
    .th_on  (TH_ON_i),
    .th_off (TH_OFF_i),
    .det    (DET_o)
  );
endmodule
